clk_freq_mon: RTL and testbench
===============================

CLK_FREQ_MON -- requirements
Module: clk_freq_mon

Interface
REQ-001 Parameter GATE_CYCLES, default 1000: length of the measurement window in clk cycles; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: width of edge count, thresholds and result; 2^CNT_W-1 SHALL be >= GATE_CYCLES/2.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 mon_clk_p  in  1  monitored clock, asynchronous to clk, sampled as data.
REQ-006 start  in  1  single-cycle request to begin one measurement.
REQ-007 cnt_min  in  CNT_W  lowest acceptable edge count, inclusive.
REQ-008 cnt_max  in  CNT_W  highest acceptable edge count, inclusive.
REQ-009 busy  out  1  high while a measurement is in progress.
REQ-010 meas_cnt  out  CNT_W  rising-edge count of the last completed measurement.
REQ-011 meas_vld  out  1  one-cycle pulse when meas_cnt, freq_ok and freq_err update.
REQ-012 freq_ok  out  1  last result within [cnt_min, cnt_max].
REQ-013 freq_err  out  1  last result outside [cnt_min, cnt_max].

Function
REQ-014 mon_clk_p SHALL pass through a 2-flop synchronizer and then a third flop; edge pulse = sync2 & ~sync3.
REQ-015 FSM states IDLE, ARM, GATE, DONE: IDLE->ARM on start; ARM->GATE after 1 cycle; GATE->DONE after exactly GATE_CYCLES cycles; DONE->IDLE after 1 cycle.
REQ-016 ARM SHALL clear the edge counter and window counter; cnt_min/cnt_max SHALL be captured in ARM and held for the measurement.
REQ-017 Edge counter SHALL increment for each edge pulse occurring in a GATE cycle; no other edges are counted.
REQ-018 Edge counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 In DONE: meas_cnt <= count; freq_ok <= (count >= min && count <= max); freq_err <= ~freq_ok; meas_vld = 1 for that cycle only.
REQ-020 meas_vld SHALL assert exactly GATE_CYCLES+2 cycles after the cycle start is sampled high in IDLE.
REQ-021 busy SHALL be high in ARM, GATE and DONE, low in IDLE.
REQ-022 start while not in IDLE SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-023 If the captured cnt_min > cnt_max, freq_ok SHALL be 0 and freq_err 1 irrespective of count.
REQ-024 meas_cnt, freq_ok and freq_err SHALL hold their values between meas_vld pulses.

Reset
REQ-025 On rst: FSM=IDLE, synchronizer flops 0, counters 0, meas_cnt=0, meas_vld=0, busy=0, freq_ok=0, freq_err=0.
REQ-026 rst during ARM/GATE/DONE SHALL abort the measurement with no meas_vld pulse; rst has priority over start.

Configuration
REQ-027 Macro CLK_FREQ_MON_DIFF_CHK_EN: when defined, port mon_clk_n (in, 1) and output diff_err (1) SHALL exist; mon_clk_n SHALL be synchronized identically to mon_clk_p.
REQ-028 With the macro defined, diff_err SHALL set when synchronized p equals synchronized n for 2 consecutive GATE cycles, stay set until the next ARM (which clears it), and reset to 0.
REQ-029 Without the macro, mon_clk_n and diff_err SHALL not exist and no complementary check logic SHALL be built.

Verification
REQ-030 GATE_CYCLES=100, mon_clk_p period 4 clk, min=24, max=26, start pulse -> meas_vld at start+102, meas_cnt=25, freq_ok=1, freq_err=0.
REQ-031 mon_clk_p held at 0, min=1 -> meas_cnt=0, freq_ok=0, freq_err=1.
REQ-032 Second start pulse 10 cycles after the first -> ignored; exactly one meas_vld at start+102.
REQ-033 rst asserted 50 cycles into GATE -> busy=0 next cycle, no meas_vld, all outputs 0; a new start then measures normally.
REQ-034 min=30, max=20 with 25-edge input -> freq_ok=0, freq_err=1.
REQ-035 With CLK_FREQ_MON_DIFF_CHK_EN, mon_clk_n tied to mon_clk_p -> diff_err=1 before DONE; a following run with mon_clk_n=~mon_clk_p -> diff_err cleared at ARM and stays 0.

Source files
------------

// File: rtl/clk_freq_mon.sv
// Gated edge counter: counts rising edges of an asynchronous clock over a
// fixed window of clk cycles and flags the result against a [min,max] range.
// Optional complementary-input check enabled by macro CLK_FREQ_MON_DIFF_CHK_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// ARM   | clear counters, capture cnt_min/cnt_max
// GATE  | count edges for exactly GATE_CYCLES cycles
// DONE  | publish result; meas_vld is registered so it appears next cycle
module clk_freq_mon #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk_p,
`ifdef CLK_FREQ_MON_DIFF_CHK_EN
  input  logic             mon_clk_n,
  output logic             diff_err,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] cnt_min,
  input  logic [CNT_W-1:0] cnt_max,
  output logic             busy,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_vld,
  output logic             freq_ok,
  output logic             freq_err
);

  localparam int              WIN_W    = 16;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_p_sync;
  logic [WIN_W-1:0]   r_win;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic [CNT_W-1:0]   r_min;
  logic [CNT_W-1:0]   r_max;
  logic [CNT_W-1:0]   r_meas_cnt;
  logic               r_meas_vld;
  logic               r_freq_ok;
  logic               r_freq_err;
  logic               w_edge;
  logic               w_in_range;

  assign w_edge     = r_p_sync[1] & ~r_p_sync[2];
  // An inverted range can never be satisfied; the explicit term makes that visible.
  assign w_in_range = (r_min <= r_max) && (r_edge_cnt >= r_min) && (r_edge_cnt <= r_max);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ARM;
      S_ARM:   w_state_nxt = S_GATE;
      S_GATE:  if (r_win == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_p_sync   <= '0;
      r_win      <= '0;
      r_edge_cnt <= '0;
      r_min      <= '0;
      r_max      <= '0;
      r_meas_cnt <= '0;
      r_meas_vld <= 1'b0;
      r_freq_ok  <= 1'b0;
      r_freq_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_p_sync   <= {r_p_sync[1:0], mon_clk_p};
      r_meas_vld <= 1'b0;
      case (r_state)
        S_ARM: begin
          r_edge_cnt <= '0;
          r_win      <= WIN_LOAD;
          r_min      <= cnt_min;
          r_max      <= cnt_max;
        end
        S_GATE: begin
          if (w_edge && (r_edge_cnt != '1)) r_edge_cnt <= r_edge_cnt + 1'b1;
          if (r_win != '0) r_win <= r_win - 1'b1;
        end
        S_DONE: begin
          r_meas_cnt <= r_edge_cnt;
          r_freq_ok  <= w_in_range;
          r_freq_err <= ~w_in_range;
          r_meas_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CLK_FREQ_MON_DIFF_CHK_EN
  logic [2:0] r_n_sync;
  logic       r_eq_prev;
  logic       r_diff_err;
  logic       w_eq;

  // Compare at the third stage so both paths see identical latency.
  assign w_eq = (r_p_sync[2] == r_n_sync[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n_sync   <= '0;
      r_eq_prev  <= 1'b0;
      r_diff_err <= 1'b0;
    end else begin
      r_n_sync <= {r_n_sync[1:0], mon_clk_n};
      case (r_state)
        S_ARM: begin
          r_eq_prev  <= 1'b0;
          r_diff_err <= 1'b0;
        end
        S_GATE: begin
          r_eq_prev <= w_eq;
          if (w_eq && r_eq_prev) r_diff_err <= 1'b1;
        end
        default: r_eq_prev <= 1'b0;
      endcase
    end
  end

  assign diff_err = r_diff_err;
`endif

  assign busy     = (r_state != S_IDLE);
  assign meas_cnt = r_meas_cnt;
  assign meas_vld = r_meas_vld;
  assign freq_ok  = r_freq_ok;
  assign freq_err = r_freq_err;

endmodule

// File: tb/tb_clk_freq_mon.sv
// Scoreboard bench for clk_freq_mon with a 100-cycle gate window; expected
// results are queued at start and checked when meas_vld fires.
module tb_clk_freq_mon;
  localparam int GC = 100;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mon_clk_p = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cnt_min = '0;
  logic [CW-1:0] cnt_max = '0;
  logic          busy;
  logic [CW-1:0] meas_cnt;
  logic          meas_vld;
  logic          freq_ok;
  logic          freq_err;
`ifdef CLK_FREQ_MON_DIFF_CHK_EN
  logic          mon_clk_n = 1'b0;
  logic          diff_err;
  bit            diff_inv = 1'b0;
`endif

  typedef struct {
    logic [CW-1:0] cnt;
    logic          ok;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   vld_count = 0;
  int   mode = 0;
  int   ph = 0;
  int   start_cyc = 0;

  clk_freq_mon #(.GATE_CYCLES(GC), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .mon_clk_p(mon_clk_p),
`ifdef CLK_FREQ_MON_DIFF_CHK_EN
    .mon_clk_n(mon_clk_n),
    .diff_err (diff_err),
`endif
    .start    (start),
    .cnt_min  (cnt_min),
    .cnt_max  (cnt_max),
    .busy     (busy),
    .meas_cnt (meas_cnt),
    .meas_vld (meas_vld),
    .freq_ok  (freq_ok),
    .freq_err (freq_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitored clock: mode 1 gives a 4-cycle period (2 high, 2 low), mode 0 holds low.
  always @(negedge clk) begin
    ph = ph + 1;
    mon_clk_p = (mode == 1) ? ((ph % 4) >= 2) : 1'b0;
`ifdef CLK_FREQ_MON_DIFF_CHK_EN
    mon_clk_n = diff_inv ? ~mon_clk_p : mon_clk_p;
`endif
    if (meas_vld === 1'b1) vld_count = vld_count + 1;
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_start(input logic [CW-1:0] mn, input logic [CW-1:0] mx,
                          input logic [CW-1:0] ecnt, input logic eok, input bit push);
    exp_t e;
    @(negedge clk);
    cnt_min = mn;
    cnt_max = mx;
    start   = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
    if (push) begin
      e.cnt = ecnt;
      e.ok  = eok;
      e.err = ~eok;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   n = 0;
    bit   got = 1'b0;
    while (n < 300 && !got) begin
      @(negedge clk);
      n++;
      if (meas_vld === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout got=no_vld exp=vld", tag);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    checks++;
    if ((cyc - start_cyc) !== (GC + 2)) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", tag, cyc - start_cyc, GC + 2);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s_unexpected_vld got=vld exp=none", tag);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (meas_cnt !== e.cnt) begin
      failures++;
      $display("FAIL %s_cnt got=%0d exp=%0d", tag, meas_cnt, e.cnt);
    end
    checks++;
    if (freq_ok !== e.ok) begin
      failures++;
      $display("FAIL %s_ok got=%0b exp=%0b", tag, freq_ok, e.ok);
    end
    checks++;
    if (freq_err !== e.err) begin
      failures++;
      $display("FAIL %s_err got=%0b exp=%0b", tag, freq_err, e.err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(3);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++;
    if (meas_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b exp=0", meas_vld); end
    checks++;
    if (meas_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", meas_cnt); end
    checks++;
    if (freq_ok !== 1'b0) begin failures++; $display("FAIL reset_ok got=%0b exp=0", freq_ok); end
    checks++;
    if (freq_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", freq_err); end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_nominal();
    mode = 1;
    idle_cycles(10);
    do_start(16'd24, 16'd26, 16'd25, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL nominal_busy got=%0b exp=1", busy); end
    wait_result("nominal");
    @(negedge clk);
    checks++;
    if (meas_vld !== 1'b0) begin failures++; $display("FAIL nominal_vld_width got=%0b exp=0", meas_vld); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL nominal_busy_end got=%0b exp=0", busy); end
    idle_cycles(5);
    checks++;
    if (meas_cnt !== 16'd25 || freq_ok !== 1'b1) begin
      failures++;
      $display("FAIL nominal_hold got=%0d/%0b exp=25/1", meas_cnt, freq_ok);
    end
  endtask

  task automatic test_stuck_low();
    mode = 0;
    idle_cycles(10);
    do_start(16'd1, 16'd26, 16'd0, 1'b0, 1'b1);
    wait_result("stuck_low");
    mode = 1;
    idle_cycles(10);
  endtask

  task automatic test_back_to_back_start();
    int v0;
    v0 = vld_count;
    do_start(16'd24, 16'd26, 16'd25, 1'b1, 1'b1);
    idle_cycles(9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result("second_start");
    idle_cycles(150);
    checks++;
    if (vld_count - v0 !== 1) begin
      failures++;
      $display("FAIL second_start_pulses got=%0d exp=1", vld_count - v0);
    end
  endtask

  task automatic test_abort();
    int v0;
    v0 = vld_count;
    do_start(16'd24, 16'd26, 16'd25, 1'b1, 1'b0);
    idle_cycles(51);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    checks++;
    if (meas_cnt !== '0 || freq_ok !== 1'b0 || freq_err !== 1'b0 || meas_vld !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs got=%0d/%0b/%0b/%0b exp=0/0/0/0", meas_cnt, freq_ok, freq_err, meas_vld);
    end
    rst = 1'b0;
    idle_cycles(150);
    checks++;
    if (vld_count !== v0) begin failures++; $display("FAIL abort_no_vld got=%0d exp=%0d", vld_count, v0); end
    do_start(16'd24, 16'd26, 16'd25, 1'b1, 1'b1);
    wait_result("after_abort");
  endtask

  task automatic test_ranges();
    do_start(16'd30, 16'd20, 16'd25, 1'b0, 1'b1);
    wait_result("inverted_range");
    do_start(16'd25, 16'd25, 16'd25, 1'b1, 1'b1);
    wait_result("exact_bound");
    do_start(16'd26, 16'd40, 16'd25, 1'b0, 1'b1);
    wait_result("below_min");
    do_start(16'd10, 16'd24, 16'd25, 1'b0, 1'b1);
    wait_result("above_max");
  endtask

  task automatic test_capture();
    do_start(16'd24, 16'd26, 16'd25, 1'b1, 1'b1);
    idle_cycles(5);
    cnt_min = 16'd30;
    cnt_max = 16'd40;
    wait_result("captured_range");
  endtask

`ifdef CLK_FREQ_MON_DIFF_CHK_EN
  task automatic test_diff();
    diff_inv = 1'b0;
    idle_cycles(10);
    do_start(16'd24, 16'd26, 16'd25, 1'b1, 1'b1);
    idle_cycles(50);
    checks++;
    if (diff_err !== 1'b1) begin failures++; $display("FAIL diff_tied got=%0b exp=1", diff_err); end
    wait_result("diff_tied_run");
    diff_inv = 1'b1;
    idle_cycles(10);
    do_start(16'd24, 16'd26, 16'd25, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (diff_err !== 1'b0) begin failures++; $display("FAIL diff_clear got=%0b exp=0", diff_err); end
    wait_result("diff_inv_run");
    checks++;
    if (diff_err !== 1'b0) begin failures++; $display("FAIL diff_stay_clear got=%0b exp=0", diff_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_stuck_low();
    test_back_to_back_start();
    test_abort();
    test_ranges();
    test_capture();
`ifdef CLK_FREQ_MON_DIFF_CHK_EN
    test_diff();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
